irq_timer: RTL and testbench
============================

Name: irq_timer

Overview:
- Memory-mapped interval timer. It is the source end of the IRQ line that the control decoder consumes.
- The CPU programs a reload value (TH), a running count (TL) and a control/status word (TCON) through the data-memory bus.
- On TL overflow the timer reloads TL from TH and raises a level interrupt. The interrupt is held until software clears it.
- The block sits beside data memory on the single-cycle bus. Reads return combinationally, so loads complete in one cycle.

Parameters:
- BASE_ADDR, 32'h4000_0000, word address of TH. TL is at BASE+4, TCON at BASE+8.
- PRESCALE, 1, clock cycles per TL increment. Legal range 1..65535.

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high
- addr  input  32  byte address from the ALU result; addr[1:0] ignored
- rd_en  input  1  load strobe (MemRead)
- wr_en  input  1  store strobe (MemWrite)
- wdata  input  32  store data
- rdata  output  32  read data, combinational
- irq  output  1  interrupt request to the control decoder
- hit  output  1  addr[31:2] matches one of the 3 registers; used by the top-level read mux

Behaviour:
- Reset (async, active-high). TH=0, TL=0, TCON=0, prescale counter=0, irq=0. rdata is 0 while rd_en=0.
- Decode:
  - hit when addr[31:2] equals BASE[31:2], BASE[31:2]+1 or BASE[31:2]+2.
  - Writes happen on the rising clk edge when wr_en && hit.
  - rdata = selected register when rd_en && hit, else 0.
- TCON bits:
  - [0] EN: timer run.
  - [1] IE: interrupt enable.
  - [2] ST: interrupt status.
  - [3] OV: overrun, meaning an overflow occurred while ST=1.
  - [31:4] read 0, writes ignored.
  - ST and OV are set by hardware and cleared by software writing 0 to them. Writing 1 to ST or OV leaves it unchanged, so software cannot set them.
- Prescale counter (pc, 16 bit):
  - While EN=0, pc holds at 0 and TL holds.
  - While EN=1, pc increments each cycle. When pc==PRESCALE-1, pc wraps to 0 and a tick occurs.
  - With PRESCALE=1 there is a tick every cycle.
- On each tick:
  - If TL==32'hFFFF_FFFF, this is an overflow: TL<=TH.
    - If IE=1, ST<=1.
    - If IE=1 and ST was already 1, OV<=1.
  - Otherwise TL<=TL+1. Arithmetic is unsigned 32-bit.
- irq = ST & IE, registered through the ST flop. It rises the cycle after the overflow edge.
- Simultaneous events:
  - CPU write to TL in the same cycle as a tick: the write wins and the increment/reload is discarded.
  - CPU write to TH in the same cycle as an overflow: the reload uses the old TH; the new TH applies from the next overflow.
  - TCON write clearing ST in the same cycle as an overflow setting ST: the hardware set wins, so ST=1. OV follows the pre-write ST.
  - TCON write changing EN from 1 to 0: pc clears on that edge; a tick in the same cycle still takes effect.
- Reset asserted mid-count clears all state immediately, independent of clk.
- Unmapped addresses:
  - Stores do not alter any register.
  - Loads give hit=0 and rdata=0.

Decomposition:
- Shared package/header holds:
  - register offsets TH_OFF=0, TL_OFF=4, TCON_OFF=8
  - TCON bit indices EN=0, IE=1, ST=2, OV=3
  - default BASE_ADDR
- One sub-module, timer_prescaler (pc counter, EN clear, tick output), is natural.
- Register file, decode and read mux stay in irq_timer.

Test Plan:
1. Reset, then read TH, TL and TCON -> rdata 0 for each; irq=0; hit=1 for 0x4000_0000/4/8; hit=0 and rdata=0 for 0x4000_000C.
2. Write TH=FFFF_FFFC, TL=FFFF_FFFE, TCON=3 with PRESCALE=1 -> TL reads FFFF_FFFF after 1 cycle, then FFFF_FFFC on the next edge; irq=1 and TCON reads 7 one cycle after the overflow.
3. With irq=1, write TCON=3 -> irq=0 next cycle. After 4 more cycles (FFFF_FFFC→FFFF_FFFF then overflow) irq=1 again with OV=0.
4. Leave ST=1 uncleared through a second overflow -> TCON reads F; writing 3 clears both bits; rdata=3.
5. PRESCALE=4, TL=0, TCON=1 -> TL=1 after 4 cycles and TL=2 after 8. Write TCON=0 at cycle 6, then re-enable -> the next increment occurs 4 cycles after re-enable.
6. Collisions:
   - TL write of 0000_0010 on an overflow edge -> TL=0000_0010 and ST unchanged.
   - TCON clear on an overflow edge with IE=1 -> ST=1.
   - Async reset pulse mid-count -> all registers 0 before the next clk edge.

Source files
------------

// File: rtl/irq_timer_pkg.sv
// Shared definitions for the memory-mapped interval timer: register map,
// TCON bit layout and the address decoder.
package irq_timer_pkg;

  localparam logic [31:0] DEFAULT_BASE_ADDR = 32'h4000_0000;

  localparam logic [3:0] TH_OFF   = 4'd0;
  localparam logic [3:0] TL_OFF   = 4'd4;
  localparam logic [3:0] TCON_OFF = 4'd8;

  localparam int unsigned TCON_EN = 0;
  localparam int unsigned TCON_IE = 1;
  localparam int unsigned TCON_ST = 2;
  localparam int unsigned TCON_OV = 3;

  typedef enum logic [1:0] {
    SEL_NONE,
    SEL_TH,
    SEL_TL,
    SEL_TCON
  } regSel_e;

  // Member order places EN at bit 0 so the struct maps directly onto TCON[3:0].
  typedef struct packed {
    logic ov;
    logic st;
    logic ie;
    logic en;
  } tcon_t;

  function automatic regSel_e decodeAddr(input logic [29:0] addrWord,
                                         input logic [29:0] baseWord);
    logic [29:0] wordOff;
    wordOff = addrWord - baseWord;
    if (wordOff == 30'(TH_OFF >> 2))   return SEL_TH;
    if (wordOff == 30'(TL_OFF >> 2))   return SEL_TL;
    if (wordOff == 30'(TCON_OFF >> 2)) return SEL_TCON;
    return SEL_NONE;
  endfunction

endpackage

// File: rtl/irq_timer_prescaler.sv
// Prescale counter: divides the clock by PRESCALE while the timer runs and
// emits a one-cycle tick on the last count of each period.
module timer_prescaler #(
  parameter int unsigned PRESCALE = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic stop,
  output logic tick
);

  localparam logic [15:0] LAST = 16'(PRESCALE - 1);

  logic [15:0] pc;
  logic [15:0] pcNext;

  assign tick = en && (pc == LAST);

  // A disabling write clears pc on the same edge, but a tick already due still fires.
  always_comb begin
    pcNext = pc;
    if (!en || stop || tick) begin
      pcNext = '0;
    end else begin
      pcNext = pc + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc <= '0;
    end else begin
      pc <= pcNext;
    end
  end

endmodule

// File: rtl/irq_timer.sv
// Memory-mapped interval timer: TH reload, TL running count and TCON
// control/status on the data-memory bus, raising a held level interrupt.
module irq_timer
  import irq_timer_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = DEFAULT_BASE_ADDR,
  parameter int unsigned PRESCALE  = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic        rd_en,
  input  logic        wr_en,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        irq,
  output logic        hit
);

  regSel_e     sel;
  logic        wrTh;
  logic        wrTl;
  logic        wrTcon;
  logic        stop;
  logic        tick;
  logic        overflow;
  logic [31:0] th;
  logic [31:0] tl;
  tcon_t       tcon;
  tcon_t       tconNext;
  logic        unusedAddrLsb;

  assign unusedAddrLsb = ^addr[1:0];

  assign sel    = decodeAddr(addr[31:2], BASE_ADDR[31:2]);
  assign hit    = (sel != SEL_NONE);
  assign wrTh   = wr_en && (sel == SEL_TH);
  assign wrTl   = wr_en && (sel == SEL_TL);
  assign wrTcon = wr_en && (sel == SEL_TCON);
  assign stop   = wrTcon && !wdata[TCON_EN];

  timer_prescaler #(
    .PRESCALE(PRESCALE)
  ) uPrescaler (
    .clk  (clk),
    .reset(reset),
    .en   (tcon.en),
    .stop (stop),
    .tick (tick)
  );

  // A CPU store to TL discards the whole overflow, including the status set.
  assign overflow = tick && (tl == '1) && !wrTl;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      th <= '0;
    end else if (wrTh) begin
      th <= wdata;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tl <= '0;
    end else if (wrTl) begin
      tl <= wdata;
    end else if (tick) begin
      tl <= (tl == '1) ? th : tl + 32'd1;
    end
  end

  // Hardware set of ST/OV is applied after the software clear so it wins.
  always_comb begin
    tconNext = tcon;
    if (wrTcon) begin
      tconNext.en = wdata[TCON_EN];
      tconNext.ie = wdata[TCON_IE];
      if (!wdata[TCON_ST]) tconNext.st = 1'b0;
      if (!wdata[TCON_OV]) tconNext.ov = 1'b0;
    end
    if (overflow && tcon.ie) begin
      tconNext.st = 1'b1;
      if (tcon.st) tconNext.ov = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tcon <= '0;
    end else begin
      tcon <= tconNext;
    end
  end

  assign irq = tcon.st & tcon.ie;

  always_comb begin
    rdata = '0;
    if (rd_en) begin
      case (sel)
        SEL_TH:   rdata = th;
        SEL_TL:   rdata = tl;
        SEL_TCON: rdata = {28'd0, tcon};
        default:  rdata = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_irq_timer.sv
// Bench for irq_timer: constant-expectation vector table, directed corner
// sequences, then randomized bus traffic against a behavioural model.
module tb_irq_timer;

  localparam logic [31:0] B   = 32'h4000_0000;
  localparam logic [31:0] ATH = B;
  localparam logic [31:0] ATL = B + 32'd4;
  localparam logic [31:0] ATC = B + 32'd8;
  localparam logic [31:0] AUN = B + 32'd12;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] addr = '0;
  logic        rd_en = 1'b0;
  logic        wr_en = 1'b0;
  logic [31:0] wdata = '0;
  logic [31:0] rdata1, rdata4;
  logic        irq1, irq4, hit1, hit4;

  int unsigned nChecks = 0;
  int unsigned nErrors = 0;

  always #5 clk = ~clk;

  irq_timer #(.BASE_ADDR(B), .PRESCALE(1)) dut1 (
    .clk(clk), .reset(reset), .addr(addr), .rd_en(rd_en), .wr_en(wr_en),
    .wdata(wdata), .rdata(rdata1), .irq(irq1), .hit(hit1)
  );

  irq_timer #(.BASE_ADDR(B), .PRESCALE(4)) dut4 (
    .clk(clk), .reset(reset), .addr(addr), .rd_en(rd_en), .wr_en(wr_en),
    .wdata(wdata), .rdata(rdata4), .irq(irq4), .hit(hit4)
  );

  // Behavioural model: ticks counted as enabled cycles modulo the prescale.
  typedef struct {
    logic [31:0] th;
    logic [31:0] tl;
    bit          en, ie, st, ov;
    int unsigned runCycles;
  } mdl_t;

  mdl_t        m[2];
  int unsigned presc[2] = '{1, 4};

  function automatic mdl_t nextState(mdl_t s, int unsigned p, logic we,
                                     logic [31:0] a, logic [31:0] d);
    mdl_t        n;
    logic [31:0] off;
    bit          wTh, wTl, wTc, tickNow, wrap;
    n       = s;
    off     = {a[31:2], 2'b00} - B;
    wTh     = we && (off == 32'd0);
    wTl     = we && (off == 32'd4);
    wTc     = we && (off == 32'd8);
    tickNow = s.en && ((s.runCycles % p) == p - 1);
    wrap    = tickNow && (s.tl == 32'hFFFF_FFFF) && !wTl;
    n.runCycles = (s.en && !(wTc && !d[0])) ? s.runCycles + 1 : 0;
    if (wTh) n.th = d;
    if (wTl) n.tl = d;
    else if (tickNow) n.tl = (s.tl == 32'hFFFF_FFFF) ? s.th : s.tl + 32'd1;
    if (wTc) begin
      n.en = d[0];
      n.ie = d[1];
      if (!d[2]) n.st = 1'b0;
      if (!d[3]) n.ov = 1'b0;
    end
    if (wrap && s.ie) begin
      n.st = 1'b1;
      if (s.st) n.ov = 1'b1;
    end
    return n;
  endfunction

  function automatic logic [32:0] modelRead(int k, logic [31:0] a, logic rd);
    logic [31:0] off;
    logic [31:0] v;
    logic        h;
    off = {a[31:2], 2'b00} - B;
    h   = (off == 32'd0) || (off == 32'd4) || (off == 32'd8);
    v   = '0;
    if (rd) begin
      if (off == 32'd0) v = m[k].th;
      else if (off == 32'd4) v = m[k].tl;
      else if (off == 32'd8) v = {28'd0, m[k].ov, m[k].st, m[k].ie, m[k].en};
    end
    return {h, v};
  endfunction

  always @(posedge clk or posedge reset) begin
    for (int k = 0; k < 2; k++) begin
      if (reset) m[k] <= '{th: '0, tl: '0, en: 0, ie: 0, st: 0, ov: 0, runCycles: 0};
      else m[k] <= nextState(m[k], presc[k], wr_en, addr, wdata);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nErrors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic wrReg(input logic [31:0] a, input logic [31:0] d);
    addr = a; wdata = d; wr_en = 1'b1; rd_en = 1'b0;
    @(posedge clk); #1;
    wr_en = 1'b0;
  endtask

  task automatic idle(input int unsigned n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic read4(input string name, input logic [31:0] a, input logic [31:0] exp);
    addr = a; rd_en = 1'b1; #1;
    check(name, rdata4, exp);
  endtask

  typedef struct {
    bit          wr;
    logic [31:0] wAddr;
    logic [31:0] wData;
    int unsigned cycles;
    bit          rd;
    logic [31:0] rAddr;
    logic [31:0] expRd;
    bit          expHit;
    bit          expIrq;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(bit wr, logic [31:0] wa, logic [31:0] wd, int unsigned cyc,
                              bit rd, logic [31:0] ra, logic [31:0] er, bit eh, bit ei);
    vec_t v;
    v = '{wr, wa, wd, cyc, rd, ra, er, eh, ei};
    return v;
  endfunction

  initial begin
    vec_t        v;
    logic [32:0] exp;
    logic [31:0] ra, wa, wd;
    int unsigned sel;

    // Expected values for the PRESCALE=1 instance (dut1).
    vecs.push_back(mk(0, '0, '0, 0, 1, ATH, 32'h0, 1, 0));
    vecs.push_back(mk(0, '0, '0, 0, 1, ATL, 32'h0, 1, 0));
    vecs.push_back(mk(0, '0, '0, 0, 1, ATC, 32'h0, 1, 0));
    vecs.push_back(mk(0, '0, '0, 0, 1, AUN, 32'h0, 0, 0));
    vecs.push_back(mk(0, '0, '0, 0, 0, ATH, 32'h0, 1, 0));
    vecs.push_back(mk(1, ATH, 32'hFFFF_FFFC, 1, 1, ATH, 32'hFFFF_FFFC, 1, 0));
    vecs.push_back(mk(1, ATL, 32'hFFFF_FFFE, 1, 1, ATL, 32'hFFFF_FFFE, 1, 0));
    vecs.push_back(mk(1, ATC, 32'h3, 1, 1, ATL, 32'hFFFF_FFFE, 1, 0));
    vecs.push_back(mk(0, '0, '0, 1, 1, ATL, 32'hFFFF_FFFF, 1, 0));
    vecs.push_back(mk(0, '0, '0, 1, 1, ATL, 32'hFFFF_FFFC, 1, 1));
    vecs.push_back(mk(0, '0, '0, 0, 1, ATC, 32'h7, 1, 1));
    vecs.push_back(mk(1, ATC, 32'h3, 1, 1, ATC, 32'h3, 1, 0));
    vecs.push_back(mk(0, '0, '0, 0, 1, ATL, 32'hFFFF_FFFD, 1, 0));
    vecs.push_back(mk(0, '0, '0, 2, 1, ATL, 32'hFFFF_FFFF, 1, 0));
    vecs.push_back(mk(0, '0, '0, 1, 1, ATC, 32'h7, 1, 1));
    vecs.push_back(mk(0, '0, '0, 4, 1, ATC, 32'hF, 1, 1));
    vecs.push_back(mk(0, '0, '0, 0, 1, ATL, 32'hFFFF_FFFC, 1, 1));
    vecs.push_back(mk(1, ATC, 32'h3, 1, 1, ATC, 32'h3, 1, 0));
    vecs.push_back(mk(0, '0, '0, 2, 1, ATL, 32'hFFFF_FFFF, 1, 0));
    vecs.push_back(mk(1, ATL, 32'h10, 1, 1, ATC, 32'h3, 1, 0));
    vecs.push_back(mk(0, '0, '0, 0, 1, ATL, 32'h10, 1, 0));
    vecs.push_back(mk(1, ATL, 32'hFFFF_FFFF, 1, 1, ATL, 32'hFFFF_FFFF, 1, 0));
    vecs.push_back(mk(1, ATH, 32'h100, 1, 1, ATL, 32'hFFFF_FFFC, 1, 1));
    vecs.push_back(mk(0, '0, '0, 0, 1, ATH, 32'h100, 1, 1));
    vecs.push_back(mk(1, ATL, 32'hFFFF_FFFF, 1, 1, ATC, 32'h7, 1, 1));
    vecs.push_back(mk(1, ATC, 32'h3, 1, 1, ATC, 32'hF, 1, 1));
    vecs.push_back(mk(0, '0, '0, 0, 1, ATL, 32'h100, 1, 1));
    vecs.push_back(mk(1, AUN, 32'hDEAD_BEEF, 1, 1, ATH, 32'h100, 1, 1));
    vecs.push_back(mk(0, '0, '0, 0, 1, AUN, 32'h0, 0, 1));
    vecs.push_back(mk(1, ATC, 32'hFFFF_FFF0, 1, 1, ATC, 32'h0, 1, 0));

    #12 reset = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < vecs.size(); i++) begin
      v = vecs[i];
      rd_en = 1'b0;
      if (v.cycles > 0) begin
        addr = v.wAddr; wdata = v.wData; wr_en = v.wr;
        @(posedge clk); #1;
        wr_en = 1'b0;
        if (v.cycles > 1) idle(v.cycles - 1);
      end
      addr = v.rAddr; rd_en = v.rd; #1;
      check($sformatf("vec%0d rdata", i), rdata1, v.expRd);
      check($sformatf("vec%0d hit", i), {31'd0, hit1}, {31'd0, v.expHit});
      check($sformatf("vec%0d irq", i), {31'd0, irq1}, {31'd0, v.expIrq});
    end

    // PRESCALE=4: increment every fourth enabled cycle, restart after disable.
    wrReg(ATL, 32'h0);
    wrReg(ATC, 32'h1);
    idle(3); read4("pre4 tl@3", ATL, 32'h0);
    idle(1); read4("pre4 tl@4", ATL, 32'h1);
    idle(1);
    wrReg(ATC, 32'h0); read4("pre4 tl stop", ATL, 32'h1);
    idle(2); read4("pre4 tl held", ATL, 32'h1);
    wrReg(ATC, 32'h1);
    idle(3); read4("pre4 tl re+3", ATL, 32'h1);
    idle(1); read4("pre4 tl re+4", ATL, 32'h2);
    idle(4); read4("pre4 tl re+8", ATL, 32'h3);

    // Asynchronous reset between clock edges.
    wrReg(ATH, 32'h5);
    wrReg(ATC, 32'h3);
    @(posedge clk); #2;
    reset = 1'b1; #2; reset = 1'b0;
    addr = ATH; rd_en = 1'b1; #1;
    check("areset th", rdata1 | rdata4, 32'h0);
    addr = ATL; #1;
    check("areset tl", rdata1 | rdata4, 32'h0);
    addr = ATC; #1;
    check("areset tcon", rdata1 | rdata4, 32'h0);
    check("areset irq", {30'd0, irq1, irq4}, 32'h0);

    // Randomized bus traffic against the model.
    @(negedge clk);
    for (int i = 0; i < 400; i++) begin
      sel = $urandom % 5;
      case (sel)
        0: begin wa = ATH; wd = ($urandom % 2) ? ($urandom | 32'hFFFF_FF00) : $urandom; end
        1: begin wa = ATL; wd = 32'hFFFF_FFF0 | ($urandom % 16); end
        2: begin
          wa = ATC;
          wd = {$urandom % 32'h1000_0000, 2'($urandom), 1'($urandom), 1'(($urandom % 5) != 0)};
        end
        3: begin wa = AUN; wd = $urandom; end
        default: begin wa = $urandom; wd = $urandom; end
      endcase
      wa[1:0] = 2'($urandom);
      addr = wa; wdata = wd; wr_en = (($urandom % 10) < 3); rd_en = 1'b0;
      @(posedge clk); #1;
      wr_en = 1'b0;
      sel = $urandom % 4;
      ra = (sel == 0) ? ATH : (sel == 1) ? ATL : (sel == 2) ? ATC : AUN;
      ra[1:0] = 2'($urandom);
      addr = ra; rd_en = (($urandom % 4) != 0); #1;
      exp = modelRead(0, ra, rd_en);
      check($sformatf("rnd%0d d1 rdata", i), rdata1, exp[31:0]);
      check($sformatf("rnd%0d d1 hit", i), {31'd0, hit1}, {31'd0, exp[32]});
      check($sformatf("rnd%0d d1 irq", i), {31'd0, irq1}, {31'd0, m[0].st & m[0].ie});
      exp = modelRead(1, ra, rd_en);
      check($sformatf("rnd%0d d4 rdata", i), rdata4, exp[31:0]);
      check($sformatf("rnd%0d d4 hit", i), {31'd0, hit4}, {31'd0, exp[32]});
      check($sformatf("rnd%0d d4 irq", i), {31'd0, irq4}, {31'd0, m[1].st & m[1].ie});
    end

    $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
    $finish;
  end

endmodule
